g3_chain_walker: RTL and testbench
==================================

// Module: g3_chain_walker
// PURPOSE
//  Lookup sequencer placed directly in front of one G3 table instance.
//  - Accepts a 5-tuple plus a chain head index.
//  - Drives the table's search index and tuple, then follows the next-index links
//    until a rule matches, the chain ends, or the hop limit is reached.
//  - Returns one result per request.
//  - Also serialises rule-update writes into the table so they never collide with a walk.
// PARAMETERS
//  NULL_INDEX  11'h7FF  next-index value that terminates a chain
//  MAX_HOPS    16       max table entries examined per lookup (1..255)
//  HOP_W       8        width of hop counter / res_hops
// PORTS
//  clk            in   1    clock
//  rst            in   1    synchronous reset, active-high
//  req_valid      in   1    lookup request valid
//  req_ready      out  1    lookup request accepted when req_valid & req_ready
//  req_head       in   11   first table index of chain
//  req_tuple      in   104  {proto[103:96], dport/sport[95:64], dstIP[63:32], srcIP[31:0]}
//  res_valid      out  1    result valid; held until res_ready
//  res_ready      in   1    result consumer ready
//  res_match      out  1    1 = rule found
//  res_ruleID     out  11   matching rule ID (0 on miss)
//  res_hops       out  HOP_W  table entries examined
//  upd_valid      in   1    table write request
//  upd_ready      out  1    write accepted when upd_valid & upd_ready
//  upd_index      in   11   entry to write
//  upd_din        in   171  entry data
//  tbl_index      out  11   search_index to table
//  tbl_tuple      out  104  tupleData to table (registered copy of req_tuple)
//  tbl_we         out  1    table write enable (one-cycle pulse)
//  tbl_din        out  171  table write data
//  tbl_match      in   1    table match (valid 1 cycle after tbl_index presented)
//  tbl_ruleID     in   11   table ruleID (same timing)
//  tbl_next_index in   11   table next_index (same timing)
// BEHAVIOUR
//  Reset values:
//  - state=IDLE.
//  - res_valid, res_match, tbl_we = 0.
//  - res_ruleID, res_hops, tbl_index = 0.
//  - tbl_tuple = 0.
//  Handshakes:
//  - upd_ready = (state==IDLE).
//  - req_ready = (state==IDLE) & ~upd_valid. Updates have priority over lookups.
//  FSM: IDLE -> ISSUE -> EVAL -> (ISSUE | DONE); IDLE -> WRITE -> IDLE.
//  IDLE:
//  - On an update handshake: register index/din, go to WRITE.
//  - On a lookup handshake:
//    - Latch req_tuple and set hops=0.
//    - If req_head==NULL_INDEX: go straight to DONE with a miss (res_hops=0, no table access).
//    - Otherwise set tbl_index=req_head and go to ISSUE.
//  WRITE:
//  - tbl_we=1 for exactly one cycle; tbl_index=upd_index, tbl_din=upd_din.
//  - Then go to IDLE.
//  ISSUE:
//  - Table samples tbl_index/tbl_tuple on this edge.
//  - hops increments; go to EVAL.
//  EVAL: sample tbl_* outputs, in priority order:
//  - tbl_match=1 -> DONE, hit (res_ruleID=tbl_ruleID).
//  - else tbl_next_index==NULL_INDEX or hops==MAX_HOPS -> DONE, miss.
//  - else tbl_index=tbl_next_index -> ISSUE.
//  Hop cost and latency:
//  - Each hop costs 2 cycles.
//  - Latency from request handshake to res_valid = 2*hops + 1 cycles.
//  DONE:
//  - res_valid=1 with stable res_match/res_ruleID/res_hops.
//  - On res_ready, clear res_valid and go to IDLE.
//  - No new request is accepted while in DONE.
//  tbl_match qualification:
//  - tbl_match is only trusted in EVAL.
//  - Before each ISSUE the walker asserts no write, so a match can only come from the entry just indexed.
//  - On a miss, res_ruleID=0.
//  Corner cases:
//  - A self-loop chain (next==own index) is bounded by MAX_HOPS and reports a miss with res_hops=MAX_HOPS.
//  - rst asserted mid-walk or mid-DONE: the result is discarded and there is no tbl_we pulse.
//  - After rst, the first handshake is possible on the cycle after rst deasserts.
// CONFIGURATION
//  G3_WALK_STATS_EN defined:
//  - Adds outputs stat_lookups[31:0] (completed lookups, wraps at 2^32) and stat_max_hops[HOP_W-1:0] (largest res_hops seen).
//  - Both update on the DONE->IDLE transition; both reset to 0.
//  G3_WALK_STATS_EN undefined:
//  - The ports and counters do not exist.
//  - All other behaviour is identical.
// TESTING
//  1. head=5, entry5 matches ruleID=42 -> res_valid at cycle 3, res_match=1, res_ruleID=42, res_hops=1.
//  2. chain 5->9->12, only 12 matches ruleID=7 -> res_hops=3, res_match=1, res_ruleID=7, latency 7 cycles.
//  3. head=NULL_INDEX -> res_valid the cycle after accept, res_match=0, res_hops=0, tbl_index unchanged.
//  4. chain 3->3 self-loop, MAX_HOPS=16 -> res_match=0, res_hops=16, res_ruleID=0.
//  5. upd_valid and req_valid both high in IDLE:
//     - The write goes first: one tbl_we pulse carrying upd_index/upd_din.
//     - The lookup is accepted 2 cycles later and sees the new entry.
//  6. res_ready held low 10 cycles -> result stable, req_ready=0; assert rst mid-walk -> res_valid=0 and IDLE next cycle.

Source files
------------

// File: rtl/g3_chain_walker.sv
// g3_chain_walker: lookup sequencer in front of one G3 table instance.
// Walks next-index chains until a rule hit, chain end or hop limit, and
// serialises table writes between walks (writes win over lookups in IDLE).
// Optional: define G3_WALK_STATS_EN to add stat_lookups / stat_max_hops.
module g3_chain_walker #(
   parameter logic [10:0] NULL_INDEX = 11'h7FF,
   parameter int          MAX_HOPS   = 16,
   parameter int          HOP_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [10:0]       req_head,
   input  logic [103:0]      req_tuple,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_match,
   output logic [10:0]       res_ruleID,
   output logic [HOP_W-1:0]  res_hops,
   input  logic              upd_valid,
   output logic              upd_ready,
   input  logic [10:0]       upd_index,
   input  logic [170:0]      upd_din,
   output logic [10:0]       tbl_index,
   output logic [103:0]      tbl_tuple,
   output logic              tbl_we,
   output logic [170:0]      tbl_din,
   input  logic              tbl_match,
   input  logic [10:0]       tbl_ruleID,
   input  logic [10:0]       tbl_next_index
`ifdef G3_WALK_STATS_EN
   ,
   output logic [31:0]       stat_lookups,
   output logic [HOP_W-1:0]  stat_max_hops
`endif
);

   typedef enum logic [2:0] {IDLE, ISSUE, EVAL, DONE, WRITE} state_t;

   state_t           state, state_nx;
   logic [HOP_W-1:0] hops;
   logic             req_hs, upd_hs, walk_end;

   assign upd_ready = (state == IDLE);
   assign req_ready = (state == IDLE) && !upd_valid;
   assign upd_hs    = upd_valid && upd_ready;
   assign req_hs    = req_valid && req_ready;
   assign res_valid = (state == DONE);
   // Chain terminates on the null link or once the hop budget is spent.
   assign walk_end  = (tbl_next_index == NULL_INDEX) || (hops == HOP_W'(MAX_HOPS));

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic; a table hit outranks chain end / hop limit
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (upd_hs)      state_nx = WRITE;
            else if (req_hs) state_nx = (req_head == NULL_INDEX) ? DONE : ISSUE;
         end
         WRITE:   state_nx = IDLE;
         ISSUE:   state_nx = EVAL;
         EVAL:    state_nx = (tbl_match || walk_end) ? DONE : ISSUE;
         DONE:    if (res_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: table drive, hop counting and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         hops       <= '0;
         res_match  <= 1'b0;
         res_ruleID <= '0;
         res_hops   <= '0;
         tbl_index  <= '0;
         tbl_tuple  <= '0;
         tbl_din    <= '0;
         tbl_we     <= 1'b0;
      end else begin
         tbl_we <= 1'b0;
         case (state)
            IDLE: begin
               if (upd_hs) begin
                  tbl_index <= upd_index;
                  tbl_din   <= upd_din;
                  tbl_we    <= 1'b1;
               end else if (req_hs) begin
                  tbl_tuple  <= req_tuple;
                  hops       <= '0;
                  res_match  <= 1'b0;
                  res_ruleID <= '0;
                  res_hops   <= '0;
                  // A null head never touches the table, so tbl_index is left alone.
                  if (req_head != NULL_INDEX) tbl_index <= req_head;
               end
            end
            ISSUE: hops <= hops + 1'b1;
            EVAL: begin
               if (tbl_match) begin
                  res_match  <= 1'b1;
                  res_ruleID <= tbl_ruleID;
                  res_hops   <= hops;
               end else if (walk_end) begin
                  res_match  <= 1'b0;
                  res_ruleID <= '0;
                  res_hops   <= hops;
               end else begin
                  tbl_index <= tbl_next_index;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef G3_WALK_STATS_EN
   // Statistics advance when a result is consumed (DONE -> IDLE)
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_lookups  <= '0;
         stat_max_hops <= '0;
      end else if (state == DONE && res_ready) begin
         stat_lookups <= stat_lookups + 32'd1;
         if (res_hops > stat_max_hops) stat_max_hops <= res_hops;
      end
   end
`endif

endmodule

// File: tb/tb_g3_chain_walker.sv
// Directed bench for g3_chain_walker with a behavioural G3 table model.
// Table entry layout used by the model:
//   [170:67] tuple, [22] match enable, [21:11] ruleID, [10:0] next_index.
module tb_g3_chain_walker;

   localparam logic [10:0] NUL = 11'h7FF;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready;
   logic [10:0]  req_head;
   logic [103:0] req_tuple;
   logic         res_valid, res_ready, res_match;
   logic [10:0]  res_ruleID;
   logic [7:0]   res_hops;
   logic         upd_valid, upd_ready;
   logic [10:0]  upd_index;
   logic [170:0] upd_din;
   logic [10:0]  tbl_index;
   logic [103:0] tbl_tuple;
   logic         tbl_we;
   logic [170:0] tbl_din;
   logic         tbl_match;
   logic [10:0]  tbl_ruleID, tbl_next_index;

   g3_chain_walker dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_head(req_head), .req_tuple(req_tuple),
      .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
      .res_ruleID(res_ruleID), .res_hops(res_hops),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_index(upd_index), .upd_din(upd_din),
      .tbl_index(tbl_index), .tbl_tuple(tbl_tuple), .tbl_we(tbl_we), .tbl_din(tbl_din),
      .tbl_match(tbl_match), .tbl_ruleID(tbl_ruleID), .tbl_next_index(tbl_next_index)
   );

   always #5 clk = ~clk;

   // Table model: registered read, one-cycle latency; bench preload port.
   logic [170:0] mem [0:2047];
   logic         tb_wr = 1'b0;
   logic [10:0]  tb_idx = '0;
   logic [170:0] tb_data = '0;
   int           we_cnt = 0;

   always @(posedge clk) begin
      if (tb_wr)  mem[tb_idx]    <= tb_data;
      if (tbl_we) mem[tbl_index] <= tbl_din;
      tbl_match      <= mem[tbl_index][22] && (mem[tbl_index][170:67] == tbl_tuple);
      tbl_ruleID     <= mem[tbl_index][21:11];
      tbl_next_index <= mem[tbl_index][10:0];
      if (tbl_we) we_cnt = we_cnt + 1;
   end

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [170:0] mk(input logic m, input logic [10:0] rule,
                                       input logic [10:0] nxt, input logic [103:0] tup);
      return {tup, 44'd0, m, rule, nxt};
   endfunction

   task automatic load(input logic [10:0] idx, input logic [170:0] d);
      @(negedge clk);
      tb_wr = 1'b1; tb_idx = idx; tb_data = d;
      @(negedge clk);
      tb_wr = 1'b0;
   endtask

   // Issue a lookup, return latency (cycles from handshake to res_valid).
   task automatic lookup(input logic [10:0] head, input logic [103:0] tup, output int lat);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_head = head; req_tuple = tup;
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      if (!res_valid) begin
         errs++; checks++;
         $display("FAIL timeout: no res_valid after %0d cycles", lat);
      end
   endtask

   typedef struct {
      logic [10:0]  head;
      logic [103:0] tup;
      logic         m;
      logic [10:0]  rule;
      logic [7:0]   hops;
      int           lat;
   } vec_t;

   vec_t vecs[7];

   initial begin
      logic [103:0] ta, tb2, tc;
      logic [10:0]  idx_before;
      logic [170:0] wd;
      int lat, we0;
      bit stable;

      ta  = {8'd6,  32'h0050_1234, 32'h0A00_0001, 32'hC0A8_0001};
      tb2 = {8'd17, 32'h0035_0035, 32'h0808_0808, 32'h0A0A_0A0A};
      tc  = {8'd1,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001};

      rst = 1'b1; req_valid = 0; req_head = '0; req_tuple = '0; res_ready = 1'b1;
      upd_valid = 0; upd_index = '0; upd_din = '0;

      // Preload while in reset: 5(TA,r42)->9(no-match)->12(TB,r7); 3 self-loop;
      // 100..115 sixteen-entry chain with hit only at 115.
      load(11'd5,  mk(1'b1, 11'd42, 11'd9,  ta));
      load(11'd9,  mk(1'b0, 11'd99, 11'd12, tb2));
      load(11'd12, mk(1'b1, 11'd7,  NUL,    tb2));
      load(11'd3,  mk(1'b0, 11'd0,  11'd3,  ta));
      for (int i = 100; i < 115; i++) load(11'(i), mk(1'b0, 11'd0, 11'(i + 1), tc));
      load(11'd115, mk(1'b1, 11'd5, NUL, ta));

      @(posedge clk); #1;
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_match", res_match, 0);
      chk("rst_res_ruleID", res_ruleID, 0);
      chk("rst_res_hops", res_hops, 0);
      chk("rst_tbl_index", tbl_index, 0);
      chk("rst_tbl_tuple", tbl_tuple, 0);
      chk("rst_tbl_we", tbl_we, 0);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("post_rst_req_ready", req_ready, 1);
      chk("post_rst_upd_ready", upd_ready, 1);

      vecs[0] = '{11'd5,   ta,  1'b1, 11'd42, 8'd1,  3};
      vecs[1] = '{11'd5,   tb2, 1'b1, 11'd7,  8'd3,  7};
      vecs[2] = '{NUL,     ta,  1'b0, 11'd0,  8'd0,  1};
      vecs[3] = '{11'd3,   ta,  1'b0, 11'd0,  8'd16, 33};
      vecs[4] = '{11'd12,  ta,  1'b0, 11'd0,  8'd1,  3};
      vecs[5] = '{11'd9,   tb2, 1'b1, 11'd7,  8'd2,  5};
      vecs[6] = '{11'd100, ta,  1'b1, 11'd5,  8'd16, 33};

      for (int v = 0; v < 7; v++) begin
         idx_before = tbl_index;
         lookup(vecs[v].head, vecs[v].tup, lat);
         chk($sformatf("v%0d_match", v), res_match, vecs[v].m);
         chk($sformatf("v%0d_ruleID", v), res_ruleID, vecs[v].rule);
         chk($sformatf("v%0d_hops", v), res_hops, vecs[v].hops);
         chk($sformatf("v%0d_latency", v), lat, vecs[v].lat);
         if (vecs[v].head == NUL) chk($sformatf("v%0d_tbl_index_kept", v), tbl_index, idx_before);
         @(posedge clk); #1;   // res_ready is high: result consumed
      end
      chk("no_we_during_lookups", we_cnt, 0);

      // Update and lookup together: write first, lookup 2 cycles later sees it.
      wd = mk(1'b1, 11'd300, NUL, tc);
      @(negedge clk);
      upd_valid = 1'b1; upd_index = 11'd40; upd_din = wd;
      req_valid = 1'b1; req_head = 11'd40; req_tuple = tc;
      #1;
      chk("prio_req_ready_low", req_ready, 0);
      chk("prio_upd_ready", upd_ready, 1);
      @(posedge clk); #1;
      upd_valid = 1'b0;
      chk("prio_we_pulse", tbl_we, 1);
      chk("prio_we_index", tbl_index, 40);
      chk("prio_we_din", tbl_din, wd);
      chk("prio_req_ready_write", req_ready, 0);
      @(posedge clk); #1;
      chk("prio_we_single", tbl_we, 0);
      chk("prio_req_ready_back", req_ready, 1);
      @(posedge clk); #1;      // lookup handshake edge
      req_valid = 1'b0;
      lat = 1;
      while (!res_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("prio_lat", lat, 3);
      chk("prio_match", res_match, 1);
      chk("prio_ruleID", res_ruleID, 300);
      chk("prio_we_count", we_cnt, 1);
      @(posedge clk); #1;

      // Backpressure: result held stable for 10 cycles, no new request accepted.
      res_ready = 1'b0;
      lookup(11'd5, ta, lat);
      req_valid = 1'b1; req_head = 11'd3; req_tuple = ta;
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (!res_valid || !res_match || res_ruleID != 11'd42 || res_hops != 8'd1 || req_ready)
            stable = 1'b0;
      end
      chk("stall_stable", stable, 1);
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release", res_valid, 0);

      // Reset mid-walk: result dropped, back to IDLE, no write pulse.
      we0 = we_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_head = 11'd3; req_tuple = ta;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_upd_ready", upd_ready, 1);
      @(negedge clk); rst = 1'b0;
      #1;
      chk("midrst_req_ready", req_ready, 1);
      chk("midrst_no_we", we_cnt, we0);
      lookup(11'd5, ta, lat);
      chk("after_rst_ruleID", res_ruleID, 42);
      chk("after_rst_lat", lat, 3);
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
